// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: state codes and timer sizing for the PLL reset sequencer
package pll_reset_pkg;
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } seq_state_e;
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/pll_reset_seq_bit_sync.sv
// bit_sync: STAGES-flop synchroniser for one asynchronous bit, reset to 0
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: pulses PLL reset, qualifies lock and releases the downstream reset
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int TIMEOUT        = 65536,
  parameter int LOCK_WAIT      = 1024,
  parameter int RELEASE_DELAY  = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  output logic                 pll_rst,
  output logic                 sys_rst,
  output logic                 ready,
  output logic [CNT_WIDTH-1:0] retry_cnt,
  output logic [CNT_WIDTH-1:0] lock_loss_cnt,
  output logic [2:0]           state
);
  localparam int TW = timer_width(PLL_RST_CYCLES, TIMEOUT, LOCK_WAIT, RELEASE_DELAY);
  seq_state_e st, st_n;
  logic [TW-1:0] timer;
  logic locked_s, retry_inc, loss_inc;
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(locked), .q(locked_s));
  // timer holds (edges spent in state - 1) at the edge being evaluated
  always_comb begin
    st_n = st;
    retry_inc = 1'b0;
    loss_inc = 1'b0;
    case (st)
      S_PLL_RST:   st_n = timer == TW'(PLL_RST_CYCLES - 1) ? S_WAIT_LOCK : S_PLL_RST;
      S_WAIT_LOCK: begin
        retry_inc = !locked_s && timer == TW'(TIMEOUT - 1);
        st_n = locked_s ? S_STABLE : retry_inc ? S_PLL_RST : S_WAIT_LOCK;
      end
      S_STABLE:    st_n = !locked_s ? S_WAIT_LOCK : timer == TW'(LOCK_WAIT - 1) ? S_RELEASE : S_STABLE;
      S_RELEASE:   begin
        loss_inc = !locked_s;
        st_n = !locked_s ? S_PLL_RST : timer == TW'(RELEASE_DELAY - 1) ? S_RUN : S_RELEASE;
      end
      S_RUN:       begin
        loss_inc = !locked_s;
        st_n = !locked_s ? S_PLL_RST : S_RUN;
      end
      default:     st_n = S_PLL_RST;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_PLL_RST;
      timer <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready <= 1'b0;
      retry_cnt <= '0;
      lock_loss_cnt <= '0;
    end else begin
      st <= st_n;
      timer <= st_n != st ? '0 : timer + TW'(1);
      pll_rst <= st_n == S_PLL_RST;
      sys_rst <= st_n != S_RUN;
      ready <= st_n == S_RUN;
      retry_cnt <= retry_cnt + CNT_WIDTH'(retry_inc && !(&retry_cnt));
      lock_loss_cnt <= lock_loss_cnt + CNT_WIDTH'(loss_inc && !(&lock_loss_cnt));
    end
  assign state = st;
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: table, directed and randomized checks against an edge-count reference model
module tb_pll_reset_seq;
  localparam int SS = 2, PRC = 4, TO = 32, LW = 8, RD = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk, rst, locked;
  logic pll_rst, sys_rst, ready;
  logic [CW-1:0] retry_cnt, lock_loss_cnt;
  logic [2:0] state;
  pll_reset_seq #(.SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC), .TIMEOUT(TO), .LOCK_WAIT(LW),
                  .RELEASE_DELAY(RD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .locked(locked), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .ready(ready), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .state(state));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  // model: phase plus the edge number it was entered on; locked history indexed by edge
  int k, m_entry, m_state, m_retry, m_loss;
  logic hist[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask
  task automatic model_reset();
    k = 0; m_entry = 0; m_state = 0; m_retry = 0; m_loss = 0;
    hist.delete();
  endtask
  task automatic model_edge(input logic l);
    logic ls;
    int el, ns;
    k++;
    ls = k > SS ? hist[k-SS-1] : 1'b0;
    hist.push_back(l);
    el = k - m_entry;
    ns = m_state;
    if (m_state == 0) ns = el == PRC ? 1 : 0;
    else if (m_state == 1) begin
      if (ls) ns = 2;
      else if (el == TO) begin ns = 0; if (m_retry < CMAX) m_retry++; end
    end else if (m_state == 2) ns = !ls ? 1 : el == LW ? 3 : 2;
    else if (!ls) begin ns = 0; if (m_loss < CMAX) m_loss++; end
    else if (m_state == 3 && el == RD) ns = 4;
    if (ns != m_state) m_entry = k;
    m_state = ns;
  endtask
  task automatic chk_model();
    chk("state", 32'(state), m_state);
    chk("pll_rst", 32'(pll_rst), 32'(m_state == 0));
    chk("sys_rst", 32'(sys_rst), 32'(m_state != 4));
    chk("ready", 32'(ready), 32'(m_state == 4));
    chk("retry_cnt", 32'(retry_cnt), m_retry);
    chk("lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
  endtask
  task automatic step(input logic l);
    locked = l;
    @(posedge clk);
    model_edge(l);
    #1;
    chk_model();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_retry"}, 32'(retry_cnt), 0);
    chk({tag, "_loss"}, 32'(lock_loss_cnt), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    model_reset();
  endtask
  typedef struct {
    logic lk; int n; logic [2:0] st; logic pr, sr, rd; logic [3:0] rc, lc;
  } vec_t;
  vec_t vt[13];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic v;
    int len, npll, guard;
    rst = 1'b1;
    locked = 1'b0;
    model_reset();
    // normal lock (s=5) then lock loss in RUN (d=25), then re-lock through full sequence
    vt[0]  = '{1'b0, 4,  3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[1]  = '{1'b1, 2,  3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[2]  = '{1'b1, 1,  3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[3]  = '{1'b1, 7,  3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[4]  = '{1'b1, 1,  3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[5]  = '{1'b1, 3,  3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[6]  = '{1'b1, 1,  3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
    vt[7]  = '{1'b1, 5,  3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
    vt[8]  = '{1'b0, 2,  3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
    vt[9]  = '{1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1};
    vt[10] = '{1'b0, 4,  3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
    vt[11] = '{1'b1, 14, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
    vt[12] = '{1'b1, 1,  3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1};
    do_reset();
    for (int r = 0; r < 13; r++) begin
      for (int i = 0; i < vt[r].n; i++) step(vt[r].lk);
      chk($sformatf("row%0d_state", r), 32'(state), 32'(vt[r].st));
      chk($sformatf("row%0d_pll_rst", r), 32'(pll_rst), 32'(vt[r].pr));
      chk($sformatf("row%0d_sys_rst", r), 32'(sys_rst), 32'(vt[r].sr));
      chk($sformatf("row%0d_ready", r), 32'(ready), 32'(vt[r].rd));
      chk($sformatf("row%0d_retry", r), 32'(retry_cnt), 32'(vt[r].rc));
      chk($sformatf("row%0d_loss", r), 32'(lock_loss_cnt), 32'(vt[r].lc));
    end
    // glitch in STABLE: back to WAIT_LOCK uncounted, then full 2+8+4 again
    do_reset();
    repeat (4) step(1'b0);
    repeat (5) step(1'b1);
    repeat (2) step(1'b0);
    chk("glitch_still_stable", 32'(state), 2);
    step(1'b0);
    chk("glitch_wait_lock", 32'(state), 1);
    chk("glitch_sys_rst", 32'(sys_rst), 1);
    chk("glitch_no_count", 32'(lock_loss_cnt), 0);
    repeat (14) step(1'b1);
    chk("glitch_release", 32'(state), 3);
    step(1'b1);
    chk("glitch_run", 32'(state), 4);
    chk("glitch_ready", 32'(ready), 1);
    // lock arriving on the timeout edge wins
    do_reset();
    repeat (33) step(1'b0);
    repeat (3) step(1'b1);
    chk("coincide_state", 32'(state), 2);
    chk("coincide_retry", 32'(retry_cnt), 0);
    // timeouts: 4-edge pll_rst pulse every 36 edges, retry saturating at 15
    do_reset();
    npll = 0;
    for (int e = 1; e <= 725; e++) begin
      step(1'b0);
      if (e >= 5 && pll_rst) npll++;
      if (e == 4) chk("to_pll_fall", 32'(pll_rst), 0);
      if (e == 36) chk("to_first_pulse", 32'(pll_rst), 1);
      if (e == 36) chk("to_first_retry", 32'(retry_cnt), 1);
      if (e == 40) chk("to_pulse_end", 32'(state), 1);
    end
    chk("to_pulse_edges", npll, 80);
    chk("to_retry_sat", 32'(retry_cnt), 15);
    // async reset mid-RELEASE, between edges
    guard = 0;
    while (m_state != 3 && guard < 100) begin
      step(1'b1);
      guard++;
    end
    chk("rel_reached", guard < 100, 1);
    step(1'b1);
    chk("rel_state", 32'(state), 3);
    #3 rst = 1'b1;
    #1 chk_reset_vals("async");
    // randomized lock segments against the model
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      v = $urandom_range(0, 9) < 7;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) step(v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

PLL bring-up and reset sequencer.
- Runs on the free-running input reference clock, upstream of the per-domain reset synchronisers.
- Pulses the PLL's reset and watches its asynchronous lock flag.
- Holds the downstream system reset until lock has been stable long enough.
- Re-runs the sequence on a lock timeout or a lock loss, and counts both events.

## Interface
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser; must be ≥2.
- `PLL_RST_CYCLES`, 8: length of each `pll_rst` pulse, in cycles; must be ≥1.
- `TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again; must be ≥1.
- `LOCK_WAIT`, 1024: consecutive cycles of synchronised lock required; must be ≥1.
- `RELEASE_DELAY`, 16: cycles of `sys_rst` hold after lock is qualified; must be ≥1.
- `CNT_WIDTH`, 8: width of the event counters.
- `clk` in 1: reference clock, free-running, not derived from the PLL.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL LOCKED; asynchronous to `clk`.
- `pll_rst` out 1: drives PLL RST.
- `sys_rst` out 1: reset for downstream clock domains.
- `ready` out 1: high in RUN only.
- `retry_cnt` out CNT_WIDTH: lock timeouts; saturates at all-ones.
- `lock_loss_cnt` out CNT_WIDTH: lock losses after qualification began; saturates at all-ones.
- `state` out 3: current state code, for debug.

## Operation
- `locked` passes through a `SYNC_STAGES`-flop synchroniser; its output is `locked_s`. Only `locked_s` is used.
- A single state timer counts edges spent in the current state and clears on every transition.

States and codes:
- PLL_RST (0): `pll_rst`=1. Goes to WAIT_LOCK on the `PLL_RST_CYCLES`-th edge in this state.
- WAIT_LOCK (1):
  - `locked_s`=1 → STABLE.
  - Otherwise, on the `TIMEOUT`-th edge → PLL_RST and `retry_cnt`+1.
  - If lock and timeout coincide, lock wins.
- STABLE (2):
  - `locked_s`=0 → WAIT_LOCK. This is not counted.
  - On the `LOCK_WAIT`-th edge with `locked_s`=1 → RELEASE.
- RELEASE (3):
  - `locked_s`=0 → PLL_RST and `lock_loss_cnt`+1.
  - Otherwise, on the `RELEASE_DELAY`-th edge → RUN.
- RUN (4): `sys_rst`=0 and `ready`=1. `locked_s`=0 → PLL_RST and `lock_loss_cnt`+1.

Output rules:
- `sys_rst`=1 in every state except RUN.
- `pll_rst`=1 only in PLL_RST.
- `pll_rst`, `sys_rst` and `ready` are dedicated flops loaded from next-state, so they change on the same edge as the state and never glitch.
- Counters saturate; they clear only on `rst`.

Reset values (asynchronous, while `rst`=1):
- state = PLL_RST, `pll_rst`=1, `sys_rst`=1, `ready`=0.
- Counters = 0, timer = 0.
- Synchroniser flops = 0.

## Timing
- Edge numbering: let `locked` first be sampled high at edge s.
- `locked_s` rises after edge s+SYNC_STAGES−1, so STABLE is entered at edge s+SYNC_STAGES.
- Then `sys_rst` falls and `ready` rises at edge s+SYNC_STAGES+LOCK_WAIT+RELEASE_DELAY.
- Lock drop sampled at edge d, in RELEASE or RUN: `pll_rst`=1, `sys_rst`=1 and `ready`=0 at edge d+SYNC_STAGES. The count increments on the same edge.
- After `rst` deasserts, `pll_rst` falls on the `PLL_RST_CYCLES`-th rising edge.
- Timeout period with no lock is TIMEOUT+PLL_RST_CYCLES edges.
- `rst` asserted in any state, including mid-timer, returns every output to its reset value without waiting for a clock edge.

## Structure
- Package `pll_reset_pkg` holds:
  - the state enum typedef (3-bit) with the codes listed above;
  - a function giving the timer width: clog2 of the largest of the timing parameters, plus 1.
- One sub-module, `bit_sync`: an N-stage synchroniser with parameter `STAGES` and an async active-high reset to 0.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, TIMEOUT=32, LOCK_WAIT=8, RELEASE_DELAY=4, CNT_WIDTH=4.

1. Reset entry and exit:
   - `rst`=1 → `pll_rst`=1, `sys_rst`=1, `ready`=0, both counters 0, `state`=0.
   - Release `rst` with `locked`=0 → `pll_rst` falls at edge 4 and `state`=1.
2. Normal lock: `locked` sampled high at edge s → `state` 2 at s+2, 3 at s+10, 4 at s+14, where `sys_rst`=0 and `ready`=1; counters stay 0.
3. Glitch during STABLE: `locked` low for 3 cycles starting at s+5 → back to WAIT_LOCK with no count. `sys_rst` stays 1. After re-lock, the full 2+8+4 sequence is required.
4. Timeout: `locked` held 0 → `pll_rst` pulses 4 cycles every 36 edges and `retry_cnt` increments per pulse. After 20 timeouts, `retry_cnt`=15.
5. Lock loss in RUN: drop sampled at d → at d+2, `pll_rst`=1, `sys_rst`=1, `ready`=0 and `lock_loss_cnt`=1. Re-lock returns to RUN after the full sequence.
6. Async reset mid-RELEASE: assert `rst` between edges → all outputs reach reset values before the next edge, counters 0, `state`=0.
